// File: rtl/ls_arbiter_if.sv
// Signal bundle linking the odd-pipe and fetch requesters, the local-store arbiter
// and the single local-store port. Bit 0 is the MSB of every vector.
interface ls_arbiter_if;
   logic         flush;
   logic         op_req;
   logic         op_wrt;
   logic [0:14]  op_addr;
   logic [0:127] op_wdata;
   logic         op_gnt;
   logic         op_rvalid;
   logic [0:127] op_rdata;
   logic         if_req;
   logic [0:14]  if_addr;
   logic         if_gnt;
   logic         if_rvalid;
   logic [0:127] if_rdata;
   logic [0:14]  LS_address;
   logic [0:127] LS_data_input;
   logic         LS_wrt_en;
   logic [0:127] LS_data_output;

   modport master (
      output flush, op_req, op_wrt, op_addr, op_wdata, if_req, if_addr, LS_data_output,
      input  op_gnt, op_rvalid, op_rdata, if_gnt, if_rvalid, if_rdata,
      input  LS_address, LS_data_input, LS_wrt_en
   );

   modport slave (
      input  flush, op_req, op_wrt, op_addr, op_wdata, if_req, if_addr, LS_data_output,
      output op_gnt, op_rvalid, op_rdata, if_gnt, if_rvalid, if_rdata,
      output LS_address, LS_data_input, LS_wrt_en
   );
endinterface

// File: rtl/ls_arbiter.sv
// Local-store arbiter: odd pipe vs instruction fetch on one quadword port, one-cycle read return.
// Optional fetch starvation guard enabled by defining LS_ARB_STARVE_GUARD_EN.
module ls_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input logic        clock,
   input logic        reset,
   ls_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      OP_RD = 2'b01,
      IF_RD = 2'b10
   } state_e;

   state_e       state_r;
   state_e       next_state_s;
   logic         promote_s;
   logic         op_gnt_s;
   logic         if_gnt_s;
   logic         op_rvalid_s;
   logic         if_rvalid_s;
   logic [0:127] op_rdata_s;
   logic [0:127] if_rdata_s;
   logic [0:14]  ls_address_s;
   logic [0:127] ls_data_input_s;
   logic         ls_wrt_en_s;

   if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_limit_range
      $error("ls_arbiter: STARVE_LIMIT must be within 1..15");
   end

`ifdef LS_ARB_STARVE_GUARD_EN
   localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);
   logic [3:0] starve_cnt_r;

   // Fetch is promoted once it has been passed over LIMIT_C times; a flush always vetoes it.
   always_comb begin
      promote_s = (starve_cnt_r == LIMIT_C) && bus.if_req && !bus.flush;
   end

   // Starvation counter: counts op wins over a live, unflushed fetch request.
   always_ff @(posedge clock) begin
      if (reset) begin
         starve_cnt_r <= 4'd0;
      end else if (if_gnt_s || !bus.if_req) begin
         starve_cnt_r <= 4'd0;
      end else if (op_gnt_s && !bus.flush && (starve_cnt_r != LIMIT_C)) begin
         starve_cnt_r <= starve_cnt_r + 4'd1;
      end else begin
         starve_cnt_r <= starve_cnt_r;
      end
   end
`else
   // Strict odd-over-fetch priority.
   always_comb begin
      promote_s = 1'b0;
   end
`endif

   // Arbitration: odd pipe wins unless fetch is promoted; flush blocks fetch only.
   always_comb begin
      op_gnt_s = 1'b0;
      if_gnt_s = 1'b0;
      if (reset) begin
         op_gnt_s = 1'b0;
         if_gnt_s = 1'b0;
      end else begin
         op_gnt_s = bus.op_req && !promote_s;
         if_gnt_s = bus.if_req && !bus.flush && !op_gnt_s;
      end
   end

   // Read-owner state register.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next state records who owns the data returning next cycle; stores return nothing.
   always_comb begin
      next_state_s = IDLE;
      if (op_gnt_s && !bus.op_wrt) begin
         next_state_s = OP_RD;
      end else if (if_gnt_s) begin
         next_state_s = IF_RD;
      end else begin
         next_state_s = IDLE;
      end
   end

   // Read return: route LS data to the owner; a flush drops fetch data in flight.
   always_comb begin
      op_rvalid_s = 1'b0;
      if_rvalid_s = 1'b0;
      case (state_r)
         OP_RD:   op_rvalid_s = !reset;
         IF_RD:   if_rvalid_s = !reset && !bus.flush;
         IDLE:    begin
            op_rvalid_s = 1'b0;
            if_rvalid_s = 1'b0;
         end
         default: begin
            op_rvalid_s = 1'b0;
            if_rvalid_s = 1'b0;
         end
      endcase
      if (op_rvalid_s) begin
         op_rdata_s = bus.LS_data_output;
      end else begin
         op_rdata_s = 128'd0;
      end
      if (if_rvalid_s) begin
         if_rdata_s = bus.LS_data_output;
      end else begin
         if_rdata_s = 128'd0;
      end
   end

   // Local-store port mux; addresses are quadword aligned by clearing the low nibble.
   always_comb begin
      ls_address_s    = 15'd0;
      ls_data_input_s = 128'd0;
      ls_wrt_en_s     = 1'b0;
      if (op_gnt_s) begin
         ls_address_s = {bus.op_addr[0:10], 4'b0000};
         ls_wrt_en_s  = bus.op_wrt;
         if (bus.op_wrt) begin
            ls_data_input_s = bus.op_wdata;
         end else begin
            ls_data_input_s = 128'd0;
         end
      end else if (if_gnt_s) begin
         ls_address_s    = {bus.if_addr[0:10], 4'b0000};
         ls_data_input_s = 128'd0;
         ls_wrt_en_s     = 1'b0;
      end else begin
         ls_address_s    = 15'd0;
         ls_data_input_s = 128'd0;
         ls_wrt_en_s     = 1'b0;
      end
   end

   assign bus.op_gnt        = op_gnt_s;
   assign bus.if_gnt        = if_gnt_s;
   assign bus.op_rvalid     = op_rvalid_s;
   assign bus.if_rvalid     = if_rvalid_s;
   assign bus.op_rdata      = op_rdata_s;
   assign bus.if_rdata      = if_rdata_s;
   assign bus.LS_address    = ls_address_s;
   assign bus.LS_data_input = ls_data_input_s;
   assign bus.LS_wrt_en     = ls_wrt_en_s;

endmodule

// File: tb/tb_ls_arbiter.sv
// Directed self-checking bench for ls_arbiter; expectations follow the guard macro setting.
module tb_ls_arbiter;

`ifdef LS_ARB_STARVE_GUARD_EN
   localparam bit GUARD_C = 1'b1;
`else
   localparam bit GUARD_C = 1'b0;
`endif

   localparam logic [127:0] Q1_C = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
   localparam logic [127:0] Q2_C = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
   localparam logic [127:0] Q3_C = 128'hA5A5_5A5A_C3C3_3C3C_0F0F_F0F0_1234_5678;
   localparam logic [127:0] W_C  = 128'hCAFE_F00D_8765_4321_0BAD_CAFE_9999_AAAA;

   logic clock;
   logic reset;
   int   errors;
   int   checks;

   ls_arbiter_if bus ();

   ls_arbiter #(.STARVE_LIMIT(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks = checks + 1;
      if (obs !== exp) begin
         errors = errors + 1;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      bus.flush          = 1'b0;
      bus.op_req         = 1'b0;
      bus.op_wrt         = 1'b0;
      bus.op_addr        = 15'd0;
      bus.op_wdata       = 128'd0;
      bus.if_req         = 1'b0;
      bus.if_addr        = 15'd0;
      bus.LS_data_output = 128'd0;
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic exp_if;
      errors = 0;
      checks = 0;
      clear_inputs();
      reset = 1'b1;
      bus.op_req = 1'b1;
      bus.if_req = 1'b1;
      bus.op_addr = 15'h0013;
      bus.LS_data_output = Q1_C;
      next_cycle();
      next_cycle();
      #2;
      check_val("rst_op_gnt", bus.op_gnt, 1'b0);
      check_val("rst_if_gnt", bus.if_gnt, 1'b0);
      check_val("rst_ls_addr", bus.LS_address, 15'd0);
      check_val("rst_ls_wen", bus.LS_wrt_en, 1'b0);
      check_val("rst_op_rvalid", bus.op_rvalid, 1'b0);
      check_val("rst_if_rdata", bus.if_rdata, 128'd0);

      // op load with unaligned address
      next_cycle();
      reset = 1'b0;
      clear_inputs();
      bus.op_req  = 1'b1;
      bus.op_addr = 15'h0013;
      #2;
      check_val("ld_op_gnt", bus.op_gnt, 1'b1);
      check_val("ld_if_gnt", bus.if_gnt, 1'b0);
      check_val("ld_ls_addr", bus.LS_address, 15'h0010);
      check_val("ld_ls_wen", bus.LS_wrt_en, 1'b0);
      check_val("ld_ls_din", bus.LS_data_input, 128'd0);

      next_cycle();
      clear_inputs();
      bus.LS_data_output = Q1_C;
      #2;
      check_val("ld_op_rvalid", bus.op_rvalid, 1'b1);
      check_val("ld_op_rdata", bus.op_rdata, Q1_C);
      check_val("ld_if_rvalid", bus.if_rvalid, 1'b0);
      check_val("idle_op_gnt", bus.op_gnt, 1'b0);
      check_val("idle_ls_addr", bus.LS_address, 15'd0);

      next_cycle();
      clear_inputs();
      bus.LS_data_output = Q2_C;
      #2;
      check_val("idle_op_rvalid", bus.op_rvalid, 1'b0);
      check_val("idle_op_rdata", bus.op_rdata, 128'd0);

      // op store beats a concurrent fetch
      next_cycle();
      clear_inputs();
      bus.op_req   = 1'b1;
      bus.op_wrt   = 1'b1;
      bus.op_addr  = 15'h0020;
      bus.op_wdata = W_C;
      bus.if_req   = 1'b1;
      bus.if_addr  = 15'h0105;
      #2;
      check_val("st_op_gnt", bus.op_gnt, 1'b1);
      check_val("st_if_gnt", bus.if_gnt, 1'b0);
      check_val("st_ls_wen", bus.LS_wrt_en, 1'b1);
      check_val("st_ls_din", bus.LS_data_input, W_C);
      check_val("st_ls_addr", bus.LS_address, 15'h0020);

      next_cycle();
      clear_inputs();
      bus.if_req  = 1'b1;
      bus.if_addr = 15'h0105;
      bus.LS_data_output = Q3_C;
      #2;
      check_val("st_no_rvalid", bus.op_rvalid, 1'b0);
      check_val("fe_if_gnt", bus.if_gnt, 1'b1);
      check_val("fe_ls_addr", bus.LS_address, 15'h0100);
      check_val("fe_ls_din", bus.LS_data_input, 128'd0);
      check_val("fe_ls_wen", bus.LS_wrt_en, 1'b0);

      // flush right after a fetch grant, op load in the same cycle
      next_cycle();
      clear_inputs();
      bus.flush   = 1'b1;
      bus.if_req  = 1'b1;
      bus.if_addr = 15'h0300;
      bus.op_req  = 1'b1;
      bus.op_addr = 15'h0047;
      bus.LS_data_output = Q2_C;
      #2;
      check_val("fl_if_rvalid", bus.if_rvalid, 1'b0);
      check_val("fl_if_rdata", bus.if_rdata, 128'd0);
      check_val("fl_if_gnt", bus.if_gnt, 1'b0);
      check_val("fl_op_gnt", bus.op_gnt, 1'b1);
      check_val("fl_ls_addr", bus.LS_address, 15'h0040);

      next_cycle();
      clear_inputs();
      bus.LS_data_output = Q3_C;
      #2;
      check_val("fl_op_rvalid", bus.op_rvalid, 1'b1);
      check_val("fl_op_rdata", bus.op_rdata, Q3_C);
      check_val("fl_if_rvalid2", bus.if_rvalid, 1'b0);

      // unflushed fetch read returns data
      next_cycle();
      clear_inputs();
      bus.if_req  = 1'b1;
      bus.if_addr = 15'h7FFF;
      #2;
      check_val("fe2_if_gnt", bus.if_gnt, 1'b1);
      check_val("fe2_ls_addr", bus.LS_address, 15'h7FF0);

      next_cycle();
      clear_inputs();
      bus.LS_data_output = Q1_C;
      #2;
      check_val("fe2_if_rvalid", bus.if_rvalid, 1'b1);
      check_val("fe2_if_rdata", bus.if_rdata, Q1_C);
      check_val("fe2_op_rvalid", bus.op_rvalid, 1'b0);

      // reset while an op load is in flight
      next_cycle();
      clear_inputs();
      bus.op_req  = 1'b1;
      bus.op_addr = 15'h0013;
      #2;
      check_val("rl_op_gnt", bus.op_gnt, 1'b1);

      next_cycle();
      reset = 1'b1;
      bus.if_req = 1'b1;
      bus.LS_data_output = Q1_C;
      #2;
      check_val("rl_op_rvalid", bus.op_rvalid, 1'b0);
      check_val("rl_op_rdata", bus.op_rdata, 128'd0);
      check_val("rl_gnts", {bus.op_gnt, bus.if_gnt}, 2'b00);
      check_val("rl_ls_addr", bus.LS_address, 15'd0);

      next_cycle();
      reset = 1'b0;
      clear_inputs();
      bus.LS_data_output = Q1_C;
      #2;
      check_val("rl_post_op_rvalid", bus.op_rvalid, 1'b0);
      check_val("rl_post_op_rdata", bus.op_rdata, 128'd0);
      check_val("rl_post_if_rvalid", bus.if_rvalid, 1'b0);

      // both requesters held high for 10 cycles
      for (int i = 0; i < 10; i++) begin
         next_cycle();
         clear_inputs();
         bus.op_req  = 1'b1;
         bus.op_addr = 15'h0100;
         bus.if_req  = 1'b1;
         bus.if_addr = 15'h0200;
         #2;
         exp_if = GUARD_C && ((i % 5) == 4);
         check_val($sformatf("prio_op_gnt_%0d", i), bus.op_gnt, !exp_if);
         check_val($sformatf("prio_if_gnt_%0d", i), bus.if_gnt, exp_if);
      end

      if (GUARD_C) begin
         for (int i = 0; i < 4; i++) begin
            next_cycle();
            bus.flush = 1'b0;
            #2;
            check_val($sformatf("sv_op_gnt_%0d", i), bus.op_gnt, 1'b1);
         end
         next_cycle();
         bus.flush = 1'b1;
         #2;
         check_val("sv_flush_op_gnt", bus.op_gnt, 1'b1);
         check_val("sv_flush_if_gnt", bus.if_gnt, 1'b0);
         next_cycle();
         bus.flush = 1'b0;
         #2;
         check_val("sv_prom_op_gnt", bus.op_gnt, 1'b0);
         check_val("sv_prom_if_gnt", bus.if_gnt, 1'b1);
         check_val("sv_prom_ls_addr", bus.LS_address, 15'h0200);
      end

      next_cycle();
      clear_inputs();
      next_cycle();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ls_arbiter.md
LS_ARBITER -- requirements
Module: ls_arbiter

Interface
REQ-001 SHALL have parameter: STARVE_LIMIT, 4, consecutive fetch denials tolerated before fetch is promoted (range 1-15).
REQ-002 SHALL have port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: flush  input  1  branch-taken flush from odd pipe.
REQ-005 SHALL have port: op_req  input  1  odd-pipe load/store request.
REQ-006 SHALL have port: op_wrt  input  1  1 = store, 0 = load.
REQ-007 SHALL have port: op_addr  input  15  odd-pipe byte address.
REQ-008 SHALL have port: op_wdata  input  128  store quadword.
REQ-009 SHALL have ports: op_gnt out 1, op_rvalid out 1, op_rdata out 128; these are the odd-pipe grant, load-return strobe and load data.
REQ-010 SHALL have ports: if_req in 1, if_addr in 15; these are the fetch quadword request and address.
REQ-011 SHALL have ports: if_gnt out 1, if_rvalid out 1, if_rdata out 128; these are the fetch grant, return strobe and data.
REQ-012 SHALL have ports: LS_address out 15, LS_data_input out 128, LS_wrt_en out 1, LS_data_output in 128; these form the single local-store port.

Function
REQ-013 SHALL grant at most one local-store access per cycle; op_gnt and if_gnt are never high together.
REQ-014 SHALL generate grants combinationally in the request cycle; the LS_* outputs carry the granted requester's address and data in that same cycle.
REQ-015 SHALL force LS_address[11:14] to 0 (quadword alignment) for both requesters.
REQ-016 SHALL drive LS_wrt_en = op_wrt only when op_gnt=1; LS_wrt_en is 0 otherwise.
REQ-017 SHALL drive LS_address = 0 and LS_data_input = 0 when there is no grant.
REQ-018 SHALL drive LS_data_input = op_wdata on an op store grant and 0 on any read.
REQ-019 SHALL use default priority: odd pipe over fetch.
REQ-020 SHALL give a granted read a one-cycle latency: in cycle N+1 the matching *_rvalid=1 and *_rdata = LS_data_output.
REQ-021 SHALL hold *_rdata at 0 whenever the matching *_rvalid=0.
REQ-022 SHALL NOT assert op_rvalid for stores.
REQ-023 SHALL track the read owner of the previous cycle in a registered state: IDLE, OP_RD or IF_RD.
REQ-024 SHALL go to OP_RD on an op load grant, IF_RD on a fetch grant, and IDLE otherwise (including op store grants).
REQ-025 SHALL, when flush=1, deny if_gnt that cycle and suppress an if_rvalid due that cycle (IF_RD data dropped).
REQ-026 SHALL leave the odd-pipe path unaffected by flush.
REQ-027 SHALL treat simultaneous flush and fetch promotion as follows: flush wins, op may be granted, and the starvation counter holds its value.
REQ-028 SHALL NOT grant a requester whose req=0; it produces no LS activity.

Reset
REQ-029 SHALL, while reset=1: drive all grants, rvalids, rdata and LS_* outputs to 0, set state to IDLE, and clear the starvation counter; no grant is given in a reset cycle.
REQ-030 SHALL, on reset mid-operation, discard a read issued in the prior cycle: no rvalid in the cycle after reset deasserts.

Configuration
REQ-031 SHALL, with macro LS_ARB_STARVE_GUARD_EN defined, implement a 4-bit starvation counter with these rules:
- increments when if_req=1, flush=0 and the cycle is granted to op;
- clears on if_gnt or when if_req=0;
- saturates at STARVE_LIMIT;
- when it equals STARVE_LIMIT, fetch takes priority over op for one grant and op_gnt=0 that cycle.
REQ-032 SHALL, without LS_ARB_STARVE_GUARD_EN, implement strict odd-over-fetch priority with no counter logic present.

Verification
REQ-033 SHALL cover: op_req=1, op_wrt=0, op_addr=0x0013 with LS_data_output=Q next cycle -> op_gnt=1, LS_address=0x0010, LS_wrt_en=0, op_rvalid=1 and op_rdata=Q at N+1.
REQ-034 SHALL cover: op store to 0x0020 together with if_req=1 -> op_gnt=1, if_gnt=0, LS_wrt_en=1, LS_data_input=op_wdata, no op_rvalid.
REQ-035 SHALL cover: guard enabled, STARVE_LIMIT=4, op_req and if_req held high -> 4 op grants, then 1 if_gnt, then the pattern repeats.
REQ-036 SHALL cover: fetch grant at cycle N, flush=1 at N+1 -> if_rvalid=0 at N+1, if_gnt=0 at N+1.
REQ-037 SHALL cover: op load granted at N, reset=1 at N+1 -> all outputs 0 at N+1 and N+2; state IDLE.
REQ-038 SHALL cover: guard disabled, both requests held for 10 cycles -> op_gnt=1 in all 10 cycles, if_gnt=0 throughout.
